// File: rtl/logic_stream_fifo_sync.sv
// logic_stream_fifo_sync: single-clock first-word-fall-through stream FIFO with registered flags.
// Define LOGIC_STREAM_FIFO_SYNC_FLUSH_EN to add a synchronous active-high flush input.
module logic_stream_fifo_sync #(
   parameter int WIDTH        = 1,
   parameter int CAPACITY     = 256,
   parameter int ALMOST_FULL  = CAPACITY-1,
   parameter int ALMOST_EMPTY = 1
) (
   input  logic                          aclk,
   input  logic                          areset_n,
   input  logic                          rx_tvalid,
   input  logic [WIDTH-1:0]              rx_tdata,
   output logic                          rx_tready,
   input  logic                          tx_tready,
   output logic                          tx_tvalid,
   output logic [WIDTH-1:0]              tx_tdata,
   output logic [$clog2(CAPACITY+1)-1:0] level,
   output logic                          almost_full,
   output logic                          almost_empty
`ifdef LOGIC_STREAM_FIFO_SYNC_FLUSH_EN
   ,
   input  logic                          flush
`endif
);
   localparam int LW = $clog2(CAPACITY+1);
   localparam int PW = $clog2(CAPACITY);
   localparam logic [LW-1:0] CAP_L = LW'(CAPACITY);
   localparam logic [LW-1:0] AF_L = LW'(ALMOST_FULL);
   localparam logic [LW-1:0] AE_L = LW'(ALMOST_EMPTY);
   localparam logic [PW-1:0] LAST = PW'(CAPACITY-1);
   logic [WIDTH-1:0] mem [CAPACITY];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] level_n;
   logic wr, rd, clr;
`ifdef LOGIC_STREAM_FIFO_SYNC_FLUSH_EN
   assign clr = flush;
`else
   assign clr = 1'b0;
`endif
   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return p == LAST ? '0 : p + PW'(1);
   endfunction
   assign wr = rx_tvalid & rx_tready;
   assign rd = tx_tvalid & tx_tready;
   assign level_n = clr ? '0 : level + LW'(wr) - LW'(rd);
   assign tx_tdata = mem[rd_ptr];
   // Storage is not reset; tx_tdata is only meaningful while tx_tvalid is high.
   always_ff @(posedge aclk)
      if (wr && !clr) mem[wr_ptr] <= rx_tdata;
   // All flags are registered from the next level so they never see tx_tready combinationally.
   always_ff @(posedge aclk or negedge areset_n)
      if (!areset_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         level        <= '0;
         rx_tready    <= 1'b1;
         tx_tvalid    <= 1'b0;
         almost_full  <= (ALMOST_FULL == 0);
         almost_empty <= 1'b1;
      end else begin
         wr_ptr       <= clr ? '0 : wr ? inc(wr_ptr) : wr_ptr;
         rd_ptr       <= clr ? '0 : rd ? inc(rd_ptr) : rd_ptr;
         level        <= level_n;
         rx_tready    <= level_n != CAP_L;
         tx_tvalid    <= level_n != '0;
         almost_full  <= level_n >= AF_L;
         almost_empty <= level_n <= AE_L;
      end
endmodule

// File: tb/tb_logic_stream_fifo_sync.sv
// tb_logic_stream_fifo_sync: directed checks of the stream FIFO in three configurations.
module tb_logic_stream_fifo_sync;
   logic aclk, areset_n;
   int errors = 0;
   int checks = 0;
   logic rv_a, rr_a, tr_a, tv_a, af_a, ae_a;
   logic [7:0] rd_a, td_a;
   logic [2:0] lv_a;
   logic rv_b, rr_b, tr_b, tv_b, af_b, ae_b;
   logic [7:0] rd_b, td_b;
   logic [1:0] lv_b;
   logic rv_c, rr_c, tr_c, tv_c, af_c, ae_c;
   logic [7:0] rd_c, td_c;
   logic [3:0] lv_c;
`ifdef LOGIC_STREAM_FIFO_SYNC_FLUSH_EN
   logic flush;
`endif
   logic_stream_fifo_sync #(.WIDTH(8), .CAPACITY(4)) u_a (
      .aclk(aclk), .areset_n(areset_n), .rx_tvalid(rv_a), .rx_tdata(rd_a), .rx_tready(rr_a),
      .tx_tready(tr_a), .tx_tvalid(tv_a), .tx_tdata(td_a), .level(lv_a),
      .almost_full(af_a), .almost_empty(ae_a)
`ifdef LOGIC_STREAM_FIFO_SYNC_FLUSH_EN
      , .flush(flush)
`endif
   );
   logic_stream_fifo_sync #(.WIDTH(8), .CAPACITY(3)) u_b (
      .aclk(aclk), .areset_n(areset_n), .rx_tvalid(rv_b), .rx_tdata(rd_b), .rx_tready(rr_b),
      .tx_tready(tr_b), .tx_tvalid(tv_b), .tx_tdata(td_b), .level(lv_b),
      .almost_full(af_b), .almost_empty(ae_b)
`ifdef LOGIC_STREAM_FIFO_SYNC_FLUSH_EN
      , .flush(1'b0)
`endif
   );
   logic_stream_fifo_sync #(.WIDTH(8), .CAPACITY(8), .ALMOST_FULL(6), .ALMOST_EMPTY(2)) u_c (
      .aclk(aclk), .areset_n(areset_n), .rx_tvalid(rv_c), .rx_tdata(rd_c), .rx_tready(rr_c),
      .tx_tready(tr_c), .tx_tvalid(tv_c), .tx_tdata(td_c), .level(lv_c),
      .almost_full(af_c), .almost_empty(ae_c)
`ifdef LOGIC_STREAM_FIFO_SYNC_FLUSH_EN
      , .flush(1'b0)
`endif
   );
   initial aclk = 1'b0;
   always #5 aclk = ~aclk;
   task automatic tick();
      @(posedge aclk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   initial begin
      areset_n = 1'b0;
      {rv_a, tr_a, rv_b, tr_b, rv_c, tr_c} = '0;
      {rd_a, rd_b, rd_c} = '0;
`ifdef LOGIC_STREAM_FIFO_SYNC_FLUSH_EN
      flush = 1'b0;
`endif
      #12;
      chk("rst_tvalid", 32'(tv_a), 0);
      chk("rst_level", 32'(lv_a), 0);
      chk("rst_rready", 32'(rr_a), 1);
      chk("rst_afull", 32'(af_a), 0);
      chk("rst_aempty", 32'(ae_a), 1);
      chk("rst_level_b", 32'(lv_b), 0);
      chk("rst_aempty_c", 32'(ae_c), 1);
      areset_n = 1'b1;
      // fill with the consumer stalled; first write lands on the first edge after release
      rv_a = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rd_a = 8'h11 * 8'(i + 1);
         tick();
         if (i == 0) begin
            chk("fill_first_tvalid", 32'(tv_a), 1);
            chk("fill_first_tdata", 32'(td_a), 'h11);
         end
      end
      chk("full_rready", 32'(rr_a), 0);
      chk("full_level", 32'(lv_a), 4);
      chk("full_afull", 32'(af_a), 1);
      chk("hold_tdata", 32'(td_a), 'h11);
      rv_a = 1'b0;
      tr_a = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_tdata", 32'(td_a), 32'('h11 * (i + 1)));
         tick();
      end
      chk("drain_level", 32'(lv_a), 0);
      chk("drain_tvalid", 32'(tv_a), 0);
      chk("drain_aempty", 32'(ae_a), 1);
      tick();
      chk("empty_read_level", 32'(lv_a), 0);
      rv_a = 1'b1;
      rd_a = 8'h01;
      tick();
      chk("empty_write_tvalid", 32'(tv_a), 1);
      chk("empty_write_level", 32'(lv_a), 1);
      tr_a = 1'b0;
      for (int i = 2; i <= 4; i++) begin
         rd_a = 8'(i);
         tick();
      end
      chk("refill_level", 32'(lv_a), 4);
      chk("refill_rready", 32'(rr_a), 0);
      // read and attempted write while full: only the read happens
      tr_a = 1'b1;
      rd_a = 8'h55;
      tick();
      chk("fullrw_level", 32'(lv_a), 3);
      chk("fullrw_rready", 32'(rr_a), 1);
      rv_a = 1'b0;
      rd_a = 8'hEE;
      tr_a = 1'b0;
      tick();
      chk("ignore_rx_level", 32'(lv_a), 3);
      tr_a = 1'b1;
      for (int i = 2; i <= 4; i++) begin
         chk("fullrw_tdata", 32'(td_a), 32'(i));
         tick();
      end
      chk("fullrw_end_tvalid", 32'(tv_a), 0);
      tr_a = 1'b0;
      // continuous stream through a 3-deep FIFO wraps pointers several times
      rv_b = 1'b1;
      tr_b = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         rd_b = 8'(k);
         tick();
         chk("wrap_level", 32'(lv_b), 1);
         chk("wrap_tdata", 32'(td_b), 32'(k));
      end
      rv_b = 1'b0;
      tick();
      chk("wrap_end_level", 32'(lv_b), 0);
      chk("wrap_end_tvalid", 32'(tv_b), 0);
      tr_b = 1'b0;
      // thresholds: almost_empty while level<=2, almost_full once level>=6
      rv_c = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         rd_c = 8'(8'hC0 + i);
         tick();
         chk("thr_level", 32'(lv_c), 32'(i));
         chk("thr_aempty", 32'(ae_c), 32'(i <= 2));
         chk("thr_afull", 32'(af_c), 32'(i >= 6));
      end
      rv_c = 1'b0;
      tr_c = 1'b1;
      chk("thr_head", 32'(td_c), 'hC1);
      tick();
      tr_c = 1'b0;
      chk("pre_rst_level", 32'(lv_c), 5);
      chk("pre_rst_tdata", 32'(td_c), 'hC2);
      chk("pre_rst_afull", 32'(af_c), 0);
      // asynchronous reset between edges
      #2;
      areset_n = 1'b0;
      #1;
      chk("async_tvalid", 32'(tv_c), 0);
      chk("async_level", 32'(lv_c), 0);
      chk("async_aempty", 32'(ae_c), 1);
      chk("async_rready", 32'(rr_c), 1);
      #2;
      areset_n = 1'b1;
      rv_c = 1'b1;
      rd_c = 8'hA5;
      tick();
      chk("post_rst_tvalid", 32'(tv_c), 1);
      chk("post_rst_tdata", 32'(td_c), 'hA5);
      chk("post_rst_level", 32'(lv_c), 1);
      rd_c = 8'hB6;
      tick();
      rv_c = 1'b0;
      tr_c = 1'b1;
      chk("post_rst_rd0", 32'(td_c), 'hA5);
      tick();
      chk("post_rst_rd1", 32'(td_c), 'hB6);
      tick();
      chk("post_rst_empty", 32'(tv_c), 0);
      tr_c = 1'b0;
`ifdef LOGIC_STREAM_FIFO_SYNC_FLUSH_EN
      rv_a = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         rd_a = 8'(8'h30 + i);
         tick();
      end
      chk("pre_flush_level", 32'(lv_a), 3);
      flush = 1'b1;
      rd_a = 8'h77;
      tick();
      flush = 1'b0;
      rv_a = 1'b0;
      chk("flush_level", 32'(lv_a), 0);
      chk("flush_tvalid", 32'(tv_a), 0);
      chk("flush_rready", 32'(rr_a), 1);
      chk("flush_aempty", 32'(ae_a), 1);
      tick();
      chk("flush_still_empty", 32'(tv_a), 0);
      rv_a = 1'b1;
      rd_a = 8'h12;
      tick();
      rv_a = 1'b0;
      chk("post_flush_tdata", 32'(td_a), 'h12);
      chk("post_flush_level", 32'(lv_a), 1);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
